// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding, default clock rate
// and the gate-counter sizing helper.
package freq_meter_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Gate counter only has to reach GATE_CYCLES-1, so clog2 of the gate length is enough.
    function automatic int gateCntWidth(input int unsigned gateCycles);
        return $clog2(gateCycles);
    endfunction

endpackage

// File: rtl/freq_meter_sync_rise_det.sv
// Multi-flop synchronizer with a rising-edge pulse on the synchronized signal.
// Usable for any asynchronous level input (buttons, external clocks, strobes).
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks
// and publishes the saturating count with a one-cycle valid pulse.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int          CNT_W       = 27,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk100MHz,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int GW = gateCntWidth(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    state_t             w_nextState;
    logic [GW-1:0]      r_gateCnt;
    logic [CNT_W-1:0]   r_edgeCnt;
    logic               r_sat;
    logic [CNT_W-1:0]   r_freqOut;
    logic               r_overflow;
    logic               r_valid;
    logic               w_rise;
    logic               w_cntAtMax;
    logic [CNT_W-1:0]   w_edgeNext;
    logic               w_satNext;

    sync_rise_det #(
        .STAGES (SYNC_STAGES)
    ) u_syncRise (
        .i_clk   (clk100MHz),
        .i_rstN  (rst_n),
        .i_async (sig_in),
        .o_rise  (w_rise)
    );

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Dropping en mid-gate abandons the gate; it takes priority even on the last gate cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_nextState = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!en) begin
                    w_nextState = ST_IDLE;
                end else if (r_gateCnt == GATE_LAST) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = en ? ST_MEASURE : ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cntAtMax = (r_edgeCnt == CNT_MAX);
        w_edgeNext = r_edgeCnt;
        if (w_rise && !w_cntAtMax) begin
            w_edgeNext = r_edgeCnt + CNT_ONE;
        end
        w_satNext = r_sat | (w_rise & w_cntAtMax);
    end

    // Results are loaded on the edge into DONE (using the next-count, so a rise in the final
    // gate cycle is included) so that freq_out, overflow and valid line up during DONE.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_gateCnt  <= '0;
            r_edgeCnt  <= '0;
            r_sat      <= 1'b0;
            r_freqOut  <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_MEASURE: begin
                    r_gateCnt <= r_gateCnt + GATE_ONE;
                    r_edgeCnt <= w_edgeNext;
                    r_sat     <= w_satNext;
                    if (w_nextState == ST_DONE) begin
                        r_freqOut  <= w_edgeNext;
                        r_overflow <= w_satNext;
                        r_valid    <= 1'b1;
                    end
                end
                default: begin
                    if (w_nextState == ST_MEASURE) begin
                        r_gateCnt <= '0;
                        r_edgeCnt <= '0;
                        r_sat     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign freq_out = r_freqOut;
    assign overflow = r_overflow;
    assign valid    = r_valid;
    assign busy     = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: directed gate sequences with periodic and random
// sig_in, checked against an edge-window model built from the sampled input history.
module tb_freq_meter;

    localparam int G    = 1000;
    localparam int W    = 8;
    localparam int SATV = (1 << W) - 1;
    localparam int MAXC = 40000;

    logic         clk100MHz = 1'b0;
    logic         rst_n     = 1'b0;
    logic         sig_in    = 1'b0;
    logic         en        = 1'b0;
    logic [W-1:0] freq_out;
    logic         valid;
    logic         overflow;
    logic         busy;

    freq_meter #(
        .CLK_HZ      (100_000_000),
        .GATE_CYCLES (G),
        .CNT_W       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .en        (en),
        .freq_out  (freq_out),
        .valid     (valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk100MHz = ~clk100MHz;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int gateStart = 0;
    int lastFreq  = 0;
    int lastOvf   = 0;
    bit samp [0:MAXC-1];

    bit sigLevel = 1'b0;
    int sigLeft  = 0;
    int hiLen    = 1;
    int loLen    = 1;
    bit randMode = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setPattern(input int hi, input int lo, input bit rnd);
        hiLen    = hi;
        loLen    = lo;
        randMode = rnd;
    endtask

    // Drive one cycle at the falling edge, record what the first synchronizer flop
    // captures at the rising edge, then return at the next falling edge.
    task automatic applyStimulus(input bit enVal);
        en = enVal;
        if (sigLeft == 0) begin
            sigLevel = ~sigLevel;
            if (randMode) sigLeft = int'($urandom_range(7, 2));
            else          sigLeft = sigLevel ? hiLen : loLen;
        end
        sigLeft--;
        sig_in = sigLevel;
        @(posedge clk100MHz);
        cyc++;
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle budget observed=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        samp[cyc] = rst_n ? sig_in : 1'b0;
        @(negedge clk100MHz);
    endtask

    // A rise first sampled at edge k is seen by the counter at edge k+2; a gate entered
    // at edge e0 counts at edges e0+1 .. e0+G.
    function automatic int expectedCount(input int e0);
        int cnt = 0;
        for (int k = e0 - 1; k <= e0 + G - 2; k++) begin
            if (samp[k] && !samp[k-1]) cnt++;
        end
        return cnt;
    endfunction

    task automatic startGate(input string tag);
        gateStart = cyc + 1;
        applyStimulus(1'b1);
        checkOutput({tag, " busy at entry"}, busy, 1);
    endtask

    task automatic runGate(input string tag);
        int e0 = gateStart;
        int badValid = 0;
        int expCnt;
        for (int i = 1; i <= G + 1; i++) begin
            applyStimulus(1'b1);
            if (i == G) begin
                expCnt   = expectedCount(e0);
                lastFreq = (expCnt > SATV) ? SATV : expCnt;
                lastOvf  = (expCnt > SATV) ? 1 : 0;
                checkOutput({tag, " valid"}, valid, 1);
                checkOutput({tag, " busy in done"}, busy, 0);
                checkOutput({tag, " freq_out"}, freq_out, lastFreq);
                checkOutput({tag, " overflow"}, overflow, lastOvf);
            end else if (valid) begin
                badValid++;
            end
            if (i == G / 2) checkOutput({tag, " busy mid"}, busy, 1);
        end
        checkOutput({tag, " stray valid"}, badValid, 0);
        gateStart = e0 + G + 1;
    endtask

    task automatic runAbort(input string tag, input int atCycle);
        int badValid = 0;
        for (int i = 1; i <= atCycle; i++) begin
            applyStimulus(1'b1);
            if (valid) badValid++;
        end
        applyStimulus(1'b0);
        checkOutput({tag, " busy after drop"}, busy, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            if (valid) badValid++;
        end
        checkOutput({tag, " no valid"}, badValid, 0);
        checkOutput({tag, " freq held"}, freq_out, lastFreq);
        checkOutput({tag, " ovf held"}, overflow, lastOvf);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " freq_out"}, freq_out, 0);
        checkOutput({tag, " valid"}, valid, 0);
        checkOutput({tag, " overflow"}, overflow, 0);
        checkOutput({tag, " busy"}, busy, 0);
    endtask

    initial begin
        samp[0] = 1'b0;

        setPattern(1, 1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        checkAllZero("reset");

        setPattern(5, 5, 1'b0);
        rst_n = 1'b1;
        startGate("p10 first");
        runGate("p10 first");
        runGate("p10 second");
        checkOutput("p10 exact", freq_out, 100);

        setPattern(2, 2, 1'b0);
        runGate("p4 first");
        runGate("p4 second");
        checkOutput("p4 exact", freq_out, 250);

        setPattern(1, 1, 1'b0);
        runGate("p2 first");
        runGate("p2 second");
        checkOutput("p2 saturated", freq_out, SATV);
        checkOutput("p2 overflow", overflow, 1);

        setPattern(2, 7, 1'b1);
        runGate("rand a");
        runGate("rand b");
        runGate("rand c");

        setPattern(5, 5, 1'b0);
        runGate("p10 after rand");
        checkOutput("p10 recover", freq_out, 100);
        checkOutput("p10 ovf clear", overflow, 0);

        runAbort("abort", 500);
        startGate("restart");
        runGate("restart");

        for (int i = 0; i < 300; i++) applyStimulus(1'b1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset now");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        checkAllZero("midreset held");
        lastFreq = 0;
        lastOvf  = 0;
        rst_n = 1'b1;
        startGate("post reset");
        runGate("post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
